// File: rtl/vga_grid_timing.sv
// vga_grid_timing
//   VGA timing generator with a COLS x ROWS cell grid over the active area and
//   a step-driven cursor that highlights one cell, latched once per frame.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   mode_toggle  one-cycle pulse, toggles IDLE/SELECT
//   step         one-cycle pulse, advance cursor (SELECT only)
//   step_back    one-cycle pulse, retreat cursor (SELECT only)
//   h_sync       horizontal sync at SYNC_POL level, 1 clock behind counters
//   v_sync       vertical sync at SYNC_POL level, 1 clock behind counters
//   active       visible pixel, 1 clock behind counters
//   cell_hit     visible pixel inside the highlighted cell, 1 clock behind
//   sel_enable   mode is SELECT
//   cursor       current cursor cell index
//   counter_x    live horizontal counter
//   counter_y    live vertical counter
//   frame_start  one-cycle pulse on the cycle after counter (0,0)
module vga_grid_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLS       = 4,
    parameter int ROWS       = 2,
    parameter bit SERPENTINE = 1'b1,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int N_CELLS   = COLS * ROWS,
    localparam int CUR_W     = $clog2(N_CELLS),
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_toggle,
    input  logic             step,
    input  logic             step_back,
    output logic             h_sync,
    output logic             v_sync,
    output logic             active,
    output logic             cell_hit,
    output logic             sel_enable,
    output logic [CUR_W-1:0] cursor,
    output logic [XW-1:0]    counter_x,
    output logic [YW-1:0]    counter_y,
    output logic             frame_start
);

    localparam int CELL_W = H_ACTIVE / COLS;
    localparam int CELL_H = V_ACTIVE / ROWS;
    localparam int CWW    = $clog2(CELL_W + 1);
    localparam int CHW    = $clog2(CELL_H + 1);
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [XW-1:0]    X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0]    X_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0]    Y_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0]    HS_FIRST = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0]    HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0]    VS_FIRST = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0]    VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CWW-1:0]   CW_LAST  = CWW'(CELL_W - 1);
    localparam logic [CHW-1:0]   CH_LAST  = CHW'(CELL_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(N_CELLS - 1);

    typedef enum logic {IDLE, SELECT} state_t;

    state_t             state, state_nx;
    logic [CUR_W-1:0]   cursor_nx;
    logic [CUR_W-1:0]   cursor_frame;
    logic [CWW-1:0]     col_cnt_p0;
    logic [CHW-1:0]     row_cnt_p0;
    logic [COL_W-1:0]   col_p0;
    logic [ROW_W-1:0]   row_p0;
    logic [CUR_W-1:0]   pix_idx_p0;
    logic [CUR_W-1:0]   hit_cursor_p0;
    logic               frame_origin_p0;
    logic               in_active_p0;

    assign sel_enable = (state == SELECT);

    // Mode FSM and cursor
    always_comb begin
        state_nx  = state;
        cursor_nx = cursor;
        if (mode_toggle) begin
            // Toggle wins over any same-cycle step; cursor is 0 in both directions.
            state_nx  = (state == IDLE) ? SELECT : IDLE;
            cursor_nx = '0;
        end else if (state == SELECT) begin
            if (step && !step_back) begin
                cursor_nx = (cursor == CUR_LAST) ? '0 : cursor + CUR_W'(1);
            end else if (step_back && !step) begin
                cursor_nx = (cursor == '0) ? CUR_LAST : cursor - CUR_W'(1);
            end
        end else begin
            cursor_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cursor <= '0;
        end else begin
            state  <= state_nx;
            cursor <= cursor_nx;
        end
    end

    // Stage 0: live counters and cell sub-counters aligned with them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_x  <= '0;
            counter_y  <= '0;
            col_cnt_p0 <= '0;
            col_p0     <= '0;
            row_cnt_p0 <= '0;
            row_p0     <= '0;
        end else begin
            if (counter_x == X_LAST) begin
                counter_x  <= '0;
                col_cnt_p0 <= '0;
                col_p0     <= '0;
                if (counter_y == Y_LAST) begin
                    counter_y  <= '0;
                    row_cnt_p0 <= '0;
                    row_p0     <= '0;
                end else begin
                    counter_y <= counter_y + YW'(1);
                    if (row_cnt_p0 == CH_LAST) begin
                        row_cnt_p0 <= '0;
                        // Clamp in vertical blanking; active gates the value there.
                        if (row_p0 != ROW_LAST) row_p0 <= row_p0 + ROW_W'(1);
                    end else begin
                        row_cnt_p0 <= row_cnt_p0 + CHW'(1);
                    end
                end
            end else begin
                counter_x <= counter_x + XW'(1);
                if (col_cnt_p0 == CW_LAST) begin
                    col_cnt_p0 <= '0;
                    if (col_p0 != COL_LAST) col_p0 <= col_p0 + COL_W'(1);
                end else begin
                    col_cnt_p0 <= col_cnt_p0 + CWW'(1);
                end
            end
        end
    end

    always_comb begin
        pix_idx_p0 = CUR_W'(int'(row_p0) * COLS + int'(col_p0));
        if (SERPENTINE && row_p0[0]) begin
            pix_idx_p0 = CUR_W'(int'(row_p0) * COLS + (COLS - 1 - int'(col_p0)));
        end
    end

    assign frame_origin_p0 = (counter_x == '0) && (counter_y == '0);
    assign in_active_p0    = (counter_x < X_ACT) && (counter_y < Y_ACT);
    // At the origin cursor_frame is being reloaded on this same edge, so the
    // first pixel of the frame must already compare against the new value.
    assign hit_cursor_p0   = frame_origin_p0 ? cursor : cursor_frame;

    // Stage 1: registered timing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sync       <= ~SYNC_POL;
            v_sync       <= ~SYNC_POL;
            active       <= 1'b0;
            cell_hit     <= 1'b0;
            frame_start  <= 1'b0;
            cursor_frame <= '0;
        end else begin
            h_sync       <= (counter_x >= HS_FIRST && counter_x <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            v_sync       <= (counter_y >= VS_FIRST && counter_y <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            active       <= in_active_p0;
            cell_hit     <= in_active_p0 && sel_enable && (pix_idx_p0 == hit_cursor_p0);
            frame_start  <= frame_origin_p0;
            if (frame_origin_p0) cursor_frame <= cursor;
        end
    end

endmodule

// File: tb/tb_vga_grid_timing.sv
// tb_vga_grid_timing
//   Three instances share one stimulus stream: a small serpentine grid, the
//   same timing with linear numbering, and the 800x600 8x4 generic with
//   active-high sync. A cycle-level reference computes expected outputs from
//   frame position with plain division and modulo; a monitor pops and compares.
module tb_vga_grid_timing;

    localparam int NK = 3;
    localparam int HA  [NK] = '{16, 16, 800};
    localparam int HF  [NK] = '{2, 2, 40};
    localparam int HS  [NK] = '{3, 3, 128};
    localparam int HB  [NK] = '{3, 3, 88};
    localparam int VA  [NK] = '{8, 8, 600};
    localparam int VF  [NK] = '{1, 1, 1};
    localparam int VS  [NK] = '{2, 2, 4};
    localparam int VB  [NK] = '{1, 1, 23};
    localparam int CO  [NK] = '{4, 4, 8};
    localparam int RO  [NK] = '{2, 2, 4};
    localparam int SP  [NK] = '{1, 0, 1};
    localparam int POL [NK] = '{0, 0, 1};

    localparam int XW0 = $clog2(24);
    localparam int YW0 = $clog2(12);
    localparam int CW0 = $clog2(8);
    localparam int XW2 = $clog2(1056);
    localparam int YW2 = $clog2(628);
    localparam int CW2 = $clog2(32);

    logic clk = 1'b0;
    logic rst_n, mode_toggle, step, step_back;

    logic hs0, vs0, act0, hit0, sel0, fs0;
    logic [CW0-1:0] cur0;
    logic [XW0-1:0] cx0;
    logic [YW0-1:0] cy0;
    logic hs1, vs1, act1, hit1, sel1, fs1;
    logic [CW0-1:0] cur1;
    logic [XW0-1:0] cx1;
    logic [YW0-1:0] cy1;
    logic hs2, vs2, act2, hit2, sel2, fs2;
    logic [CW2-1:0] cur2;
    logic [XW2-1:0] cx2;
    logic [YW2-1:0] cy2;

    always #5 clk = ~clk;

    vga_grid_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .COLS(4), .ROWS(2), .SERPENTINE(1'b1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .mode_toggle(mode_toggle), .step(step),
        .step_back(step_back), .h_sync(hs0), .v_sync(vs0), .active(act0),
        .cell_hit(hit0), .sel_enable(sel0), .cursor(cur0), .counter_x(cx0),
        .counter_y(cy0), .frame_start(fs0)
    );

    vga_grid_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .COLS(4), .ROWS(2), .SERPENTINE(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .mode_toggle(mode_toggle), .step(step),
        .step_back(step_back), .h_sync(hs1), .v_sync(vs1), .active(act1),
        .cell_hit(hit1), .sel_enable(sel1), .cursor(cur1), .counter_x(cx1),
        .counter_y(cy1), .frame_start(fs1)
    );

    vga_grid_timing #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .SYNC_POL(1'b1), .COLS(8), .ROWS(4), .SERPENTINE(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .mode_toggle(mode_toggle), .step(step),
        .step_back(step_back), .h_sync(hs2), .v_sync(vs2), .active(act2),
        .cell_hit(hit2), .sel_enable(sel2), .cursor(cur2), .counter_x(cx2),
        .counter_y(cy2), .frame_start(fs2)
    );

    typedef struct {
        bit hs, vs, act, hit, fs, sel;
        int cur, cx, cy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t mon_e;

    int n_chk = 0;
    int n_err = 0;
    bit started = 1'b0;

    // Reference state: position within the frame, mode, cursor, latched cursor.
    int m_pos  [NK];
    int m_mode [NK];
    int m_cur  [NK];
    int m_curf [NK];

    task automatic chk(input string nm, input int k, input int act_v, input int exp_v);
        n_chk++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, k, $time, act_v, exp_v);
        end
    endtask

    function automatic exp_t model_step(input int k, input bit mt, input bit st,
                                        input bit sb, input bit rn);
        exp_t e;
        int ht, vt, x, y, cfn, col, row, idx, n;
        ht = HA[k] + HF[k] + HS[k] + HB[k];
        vt = VA[k] + VF[k] + VS[k] + VB[k];
        n  = CO[k] * RO[k];
        if (!rn) begin
            m_pos[k] = 0; m_mode[k] = 0; m_cur[k] = 0; m_curf[k] = 0;
            e.hs = (POL[k] == 0); e.vs = (POL[k] == 0);
            e.act = 0; e.hit = 0; e.fs = 0; e.sel = 0;
            e.cur = 0; e.cx = 0; e.cy = 0;
            return e;
        end
        x = m_pos[k] % ht;
        y = m_pos[k] / ht;
        cfn = (m_pos[k] == 0) ? m_cur[k] : m_curf[k];
        e.hs = (x >= HA[k] + HF[k] && x < HA[k] + HF[k] + HS[k]) ? (POL[k] != 0) : (POL[k] == 0);
        e.vs = (y >= VA[k] + VF[k] && y < VA[k] + VF[k] + VS[k]) ? (POL[k] != 0) : (POL[k] == 0);
        e.act = (x < HA[k]) && (y < VA[k]);
        e.fs  = (m_pos[k] == 0);
        col = x / (HA[k] / CO[k]);
        row = y / (VA[k] / RO[k]);
        idx = (SP[k] != 0 && row % 2 == 1) ? row * CO[k] + (CO[k] - 1 - col) : row * CO[k] + col;
        e.hit = e.act && (m_mode[k] != 0) && (idx == cfn);
        if (mt) begin
            m_mode[k] = (m_mode[k] == 0) ? 1 : 0;
            m_cur[k] = 0;
        end else if (m_mode[k] != 0) begin
            if (st && !sb) m_cur[k] = (m_cur[k] + 1) % n;
            else if (sb && !st) m_cur[k] = (m_cur[k] + n - 1) % n;
        end
        m_curf[k] = cfn;
        m_pos[k] = (m_pos[k] + 1) % (ht * vt);
        e.sel = (m_mode[k] != 0);
        e.cur = m_cur[k];
        e.cx = m_pos[k] % ht;
        e.cy = m_pos[k] / ht;
        return e;
    endfunction

    task automatic cmp(input int k, input exp_t e, input bit hs, input bit vs, input bit ac,
                       input bit ht, input bit fs, input bit se, input int cu, input int cx,
                       input int cy);
        chk("h_sync", k, int'(hs), int'(e.hs));
        chk("v_sync", k, int'(vs), int'(e.vs));
        chk("active", k, int'(ac), int'(e.act));
        chk("cell_hit", k, int'(ht), int'(e.hit));
        chk("frame_start", k, int'(fs), int'(e.fs));
        chk("sel_enable", k, int'(se), int'(e.sel));
        chk("cursor", k, cu, e.cur);
        chk("counter_x", k, cx, e.cx);
        chk("counter_y", k, cy, e.cy);
    endtask

    // Monitor: every clock after the first push, pop one expectation per DUT.
    always @(posedge clk) begin
        #1;
        if (started) begin
            if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                mon_e = q0.pop_front();
                cmp(0, mon_e, hs0, vs0, act0, hit0, fs0, sel0, int'(cur0), int'(cx0), int'(cy0));
                mon_e = q1.pop_front();
                cmp(1, mon_e, hs1, vs1, act1, hit1, fs1, sel1, int'(cur1), int'(cx1), int'(cy1));
                mon_e = q2.pop_front();
                cmp(2, mon_e, hs2, vs2, act2, hit2, fs2, sel2, int'(cur2), int'(cx2), int'(cy2));
            end
        end
    end

    task automatic check_reset_now();
        chk("async_rst_counter_x", 0, int'(cx0), 0);
        chk("async_rst_counter_y", 0, int'(cy0), 0);
        chk("async_rst_h_sync", 0, int'(hs0), 1);
        chk("async_rst_v_sync", 0, int'(vs0), 1);
        chk("async_rst_active", 0, int'(act0), 0);
        chk("async_rst_cell_hit", 0, int'(hit0), 0);
        chk("async_rst_frame_start", 0, int'(fs0), 0);
        chk("async_rst_sel_enable", 0, int'(sel0), 0);
        chk("async_rst_cursor", 0, int'(cur0), 0);
        chk("async_rst_h_sync", 2, int'(hs2), 0);
        chk("async_rst_counter_x", 2, int'(cx2), 0);
    endtask

    task automatic drive(input bit mt, input bit st, input bit sb, input bit rn);
        @(negedge clk);
        mode_toggle = mt;
        step = st;
        step_back = sb;
        if (!rn && rst_n) begin
            rst_n = 1'b0;
            #1;
            check_reset_now();
        end else begin
            rst_n = rn;
        end
        q0.push_back(model_step(0, mt, st, sb, rn));
        q1.push_back(model_step(1, mt, st, sb, rn));
        q2.push_back(model_step(2, mt, st, sb, rn));
        started = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic random_run(input int n);
        bit mt, st, sb;
        for (int i = 0; i < n; i++) begin
            mt = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 7) == 0);
            sb = ($urandom_range(0, 11) == 0);
            drive(mt, st, sb, 1'b1);
        end
    endtask

    task automatic idle_until_pos0(input int target);
        int guard;
        guard = 0;
        while (m_pos[0] != target && guard < 400) begin
            idle(1);
            guard++;
        end
        if (guard >= 400) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_position: got %0d expected %0d", m_pos[0], target);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode_toggle = 1'b0;
        step = 1'b0;
        step_back = 1'b0;
        for (int k = 0; k < NK; k++) begin
            m_pos[k] = 0; m_mode[k] = 0; m_cur[k] = 0; m_curf[k] = 0;
        end

        // Held in reset, then released.
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Cursor wrap: eight steps come back to 0, one step back gives N-1.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            idle(2);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Cursor 7 -> 4, then let two full frames show the highlighted cell.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            idle(1);
        end
        idle(600);

        // Step in the middle of the second cell row; old cell holds until the next frame.
        idle_until_pos0(5 * 24 + 3);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        idle(400);

        // Toggle and step together in SELECT: back to IDLE, cursor 0.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(400);

        // Randomised traffic, starting in SELECT.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        random_run(4000);

        // Reset mid-frame, then recover and keep going.
        idle(37);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle(300);
        random_run(600);

        @(posedge clk);
        #2;
        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_grid_timing.md
# vga_grid_timing

Parametrised VGA timing generator with a built-in selectable cell grid. It produces the sync, display-enable and pixel-coordinate signals for any standard mode. It also divides the active area into COLS×ROWS cells and highlights one cell under a cursor driven by step pulses. It sits between the debounced front-panel inputs and the pixel colour mux, and replaces the fixed 640×480, 4×2-grid generator.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width in lines
- SYNC_POL, 0, sync active level (0 = active-low)
- COLS / ROWS, 4 / 2, grid size; H_ACTIVE%COLS==0 and V_ACTIVE%ROWS==0 are required
- SERPENTINE, 1, 1 = odd rows numbered right-to-left

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode_toggle  in  1  one-cycle pulse, already debounced; toggles IDLE/SELECT
- step  in  1  one-cycle pulse; advance cursor
- step_back  in  1  one-cycle pulse; retreat cursor
- h_sync, v_sync  out  1  sync outputs at SYNC_POL level
- active  out  1  pixel in visible area
- cell_hit  out  1  visible pixel inside the highlighted cell
- sel_enable  out  1  mode is SELECT
- cursor  out  $clog2(COLS*ROWS)  current cursor cell index
- counter_x  out  $clog2(H_TOTAL)  horizontal counter, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
- counter_y  out  $clog2(V_TOTAL)  vertical counter
- frame_start  out  1  one-cycle pulse at the start of each frame

## Operation
- counter_x counts 0..H_TOTAL-1 and wraps. counter_y increments when counter_x==H_TOTAL-1 and wraps after V_TOTAL-1. Defaults give 800×525.
- Sync asserted when counter_x∈[H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Vertical sync uses the same rule on counter_y with the V_* parameters.
- active = counter_x<H_ACTIVE && counter_y<V_ACTIVE.
- Pixel cell column and row come from sub-counters that step every H_ACTIVE/COLS pixels and every V_ACTIVE/ROWS lines. No dividers.
- Cell index is row*COLS+col. When SERPENTINE=1 and the row is odd, the index is row*COLS+(COLS-1-col).
- Mode FSM states:
  - IDLE: reset state. Cursor is held at 0; sel_enable=0.
  - SELECT: sel_enable=1.
  - mode_toggle flips the state. Leaving SELECT clears cursor to 0.
- In SELECT, cursor updates as follows:
  - step alone: cursor+1, and N-1 wraps to 0 (N=COLS*ROWS).
  - step_back alone: cursor-1, and 0 wraps to N-1.
  - step and step_back together: no change.
- mode_toggle takes priority over a step or step_back in the same cycle; the step is discarded. Steps in IDLE are ignored.
- The highlight uses cursor_frame, a copy of cursor latched when counter_x==0 && counter_y==0. The highlight therefore never changes mid-frame.
- cell_hit = active && sel_enable && (pixel cell index == cursor_frame).

## Timing
- counter_x and counter_y are the live counter registers.
- h_sync, v_sync, active, cell_hit and frame_start are registered from the counters. They lag the counters by exactly 1 clock.
- frame_start is high on the cycle after counter_x==0 && counter_y==0.
- cursor and sel_enable update on the clock edge after the input pulse.
- cursor_frame loads on the same edge that frame_start is registered. The new cell is visible starting on the first pixel of that frame.
- Reset values:
  - counters 0
  - h_sync and v_sync at the inactive level (1 for SYNC_POL=0)
  - active, cell_hit, frame_start, sel_enable all 0
  - cursor and cursor_frame 0
  - FSM in IDLE
- Reset asserted mid-frame forces all outputs to their reset values immediately. Counting restarts at 0,0 on the first edge after release, and the first frame_start follows one cycle later.

## Test plan
- Reset and period: hold rst_n low, then release. Required:
  - all outputs read reset values;
  - frame_start pulses every 420000 clocks;
  - the h_sync low window is 96 clocks, starting 1 clock after counter_x==656;
  - the v_sync low window is 2 lines, starting at counter_y==490.
- Cursor wrap: mode_toggle, then 8 step pulses gives cursor 1,2,…,7,0. One step_back from 0 gives 7. step and step_back together leave cursor unchanged.
- Serpentine mapping: set cursor=4, then wait for the next frame. cell_hit=1 only for x∈[480,639], y∈[240,479]. With SERPENTINE=0, the same cursor highlights x∈[0,159], y∈[240,479].
- Frame latching: step at counter_y==100. The old cell stays highlighted for the rest of the frame, and the new cell appears after the next frame_start.
- Mode priority: mode_toggle and step in the same cycle while in SELECT. Required: IDLE, cursor=0, cell_hit never asserted.
- Generics: COLS=8, ROWS=4 with 800×600 timing (H 800/40/128/88, V 600/1/4/23). Required: H_TOTAL 1056, V_TOTAL 628, and a cell size of 100×150 pixels.
